vga_write_arbiter: RTL and testbench
====================================

# vga_write_arbiter

Shares the single VGA adapter write port (x, y, colour, plot) between up to N drawing engines: floor drawer, man drawer/eraser, obstacle drawer, score drawer. Each engine requests the port, streams pixels while granted, and releases it with a last-pixel flag. Grants are round-robin, held for a whole sprite or region so shapes are never interleaved. Sits between the drawing datapaths and the VGA adapter, under the game-level sequencing FSM.

## Interface
- N_REQ, 4, number of requesters (2..8)
- X_W, 8, x coordinate width (160-column screen)
- Y_W, 7, y coordinate width (120-row screen)
- C_W, 3, colour width
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester port request; held high until done or abort
- pix_valid  in  N_REQ  requester presents a pixel this cycle
- pix_last  in  N_REQ  presented pixel is the final one of the burst
- x_in  in  N_REQ*X_W  packed x; requester i in bits [i*X_W +: X_W]
- y_in  in  N_REQ*Y_W  packed y, same packing
- colour_in  in  N_REQ*C_W  packed colour, same packing
- grant  out  N_REQ  one-hot registered grant; all zero when no owner
- done  out  N_REQ  one-cycle pulse when the owner's last pixel is accepted
- x  out  X_W  registered pixel x to the VGA adapter
- y  out  Y_W  registered pixel y
- colour  out  C_W  registered pixel colour
- plot  out  1  write enable to the VGA adapter
- busy  out  1  high in ARB-owned states STREAM and RELEASE

## Operation
- States: IDLE, STREAM, RELEASE.
- Round-robin pointer ptr (width clog2(N_REQ)), reset 0.
- IDLE: grant=0. If any req bit set, winner = first set bit searching ptr, ptr+1, … modulo N_REQ. Register grant[winner]=1 and go to STREAM. Otherwise stay.
- STREAM, owner w: a pixel is accepted on an edge when req[w] & pix_valid[w]. On acceptance, register x/y/colour from slice w and set plot=1 for the next cycle. If no pixel is accepted, plot=0 next cycle.
  - Accepted pixel with pix_last[w]=1: go to RELEASE, clear grant, pulse done[w] in the next cycle, set ptr = (w+1) mod N_REQ.
  - req[w]=0 while in STREAM: abort. Any presented pixel is dropped (plot=0). Go to RELEASE, clear grant, no done pulse, set ptr = (w+1) mod N_REQ.
- RELEASE: one cycle, grant=0, then go to IDLE. New requests are arbitrated only in IDLE.
- Inputs of non-owners are ignored. pix_valid and pix_last are ignored outside STREAM.
- No width arithmetic: coordinates pass through unchanged. Bounds are the requester's responsibility.

## Timing
- Reset (synchronous, reset_n=0 at an edge): state=IDLE, ptr=0, grant=0, done=0, plot=0, x=0, y=0, colour=0, busy=0.
- Reset in mid-stream takes effect at the same edge. No done pulse and no further plot.
- req rises in cycle 0 while in IDLE: grant is high in cycle 1.
- Owner pixel accepted at the end of cycle k: plot, x, y, colour are valid in cycle k+1. One-cycle pipeline, one pixel per cycle sustained.
- Last pixel accepted at the end of cycle k: in cycle k+1, plot=1 for the last pixel, done=1, grant=0, state RELEASE. Cycle k+2 is IDLE. The next grant appears in cycle k+3 at the earliest.
- Single-pixel burst (pix_valid and pix_last in the first grant cycle) is legal.
- Requester may tie pix_valid to grant combinationally. The arbiter never combinationally depends on grant outputs.
- plot is never high in IDLE except for the trailing cycle of an accepted last pixel, which occurs in RELEASE.

## Test plan
- Reset: drive reset_n=0 for 2 cycles mid-stream -> next cycle grant=0, plot=0, done=0, x/y/colour=0, busy=0.
- Single requester: req[0]=1, 3 pixels (10,20,c5),(11,20,c5),(12,20,c5) with last on the third -> grant[0] one cycle after req. Plot high for exactly 3 consecutive cycles with those values. done[0] coincides with the third plot.
- Round-robin: req=4'b1010 held, each burst 1 pixel -> grant order 1,3,1,3. ptr reaches 2 then 0.
- Contention fairness: req=4'b1111, 2-pixel bursts -> grants 0,1,2,3,0. No interleaving of coordinates between owners.
- Abort: owner 2 drops req after 1 accepted pixel while pix_valid is high -> the second pixel is not plotted, no done pulse, next grant goes to the requester after 2.
- Gaps: owner holds pix_valid=0 for 3 cycles mid-burst -> plot low for those 3 cycles, grant held, burst completes normally.

Source files
------------

// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_write_arbiter
// Purpose  : Round-robin owner of the single VGA adapter write port. One
//            drawing engine is granted at a time and keeps the port for a
//            whole burst. Its pixels are registered onto x/y/colour/plot.
//            The burst ends on a last-pixel flag or when the owner drops req.
// Revision : 1.0 - initial release
// ============================================================================
module vga_write_arbiter #(
   parameter int N_REQ = 4,
   parameter int X_W   = 8,
   parameter int Y_W   = 7,
   parameter int C_W   = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       pix_valid,
   input  logic [N_REQ-1:0]       pix_last,
   input  logic [N_REQ*X_W-1:0]   x_in,
   input  logic [N_REQ*Y_W-1:0]   y_in,
   input  logic [N_REQ*C_W-1:0]   colour_in,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic [X_W-1:0]         x,
   output logic [Y_W-1:0]         y,
   output logic [C_W-1:0]         colour,
   output logic                   plot,
   output logic                   busy
);

   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STREAM  = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   r_done;
   logic [X_W-1:0]     r_x;
   logic [Y_W-1:0]     r_y;
   logic [C_W-1:0]     r_colour;
   logic               r_plot;

   logic               w_found;
   logic [PTR_W-1:0]   w_winner;
   logic [PTR_W:0]     w_sum;
   logic [PTR_W-1:0]   w_idx;
   logic [N_REQ-1:0]   w_onehot;
   logic [PTR_W-1:0]   w_ptr_next;
   logic [X_W-1:0]     w_sel_x;
   logic [Y_W-1:0]     w_sel_y;
   logic [C_W-1:0]     w_sel_c;

   // Pick the first requester at or after the pointer, wrapping modulo N_REQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_sum    = '0;
      w_idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(N_REQ)) begin
            w_sum = w_sum - (PTR_W+1)'(N_REQ);
         end
         w_idx = w_sum[PTR_W-1:0];
         if (!w_found && req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

   // Owner-dependent helpers: one-hot grant, pointer after the owner, pixel slice.
   always_comb begin
      w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
      w_ptr_next = (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
      w_sel_x    = x_in[int'(r_owner)*X_W +: X_W];
      w_sel_y    = y_in[int'(r_owner)*Y_W +: Y_W];
      w_sel_c    = colour_in[int'(r_owner)*C_W +: C_W];
   end

   // Arbitration FSM; every output is registered, plot/done default low each cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         r_plot   <= 1'b0;
      end else begin
         r_done <= '0;
         r_plot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_grant <= '0;
               if (w_found) begin
                  r_owner <= w_winner;
                  r_grant <= w_onehot;
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (!req[r_owner]) begin
                  // Abort: any presented pixel is dropped, no done pulse.
                  r_grant <= '0;
                  r_ptr   <= w_ptr_next;
                  r_state <= S_RELEASE;
               end else if (pix_valid[r_owner]) begin
                  r_plot   <= 1'b1;
                  r_x      <= w_sel_x;
                  r_y      <= w_sel_y;
                  r_colour <= w_sel_c;
                  if (pix_last[r_owner]) begin
                     r_grant          <= '0;
                     r_done[r_owner]  <= 1'b1;
                     r_ptr            <= w_ptr_next;
                     r_state          <= S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign grant  = r_grant;
   assign done   = r_done;
   assign x      = r_x;
   assign y      = r_y;
   assign colour = r_colour;
   assign plot   = r_plot;
   assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_write_arbiter
// Purpose  : Directed self-checking bench for vga_write_arbiter. Inputs are
//            driven 1 ns after each rising edge, and outputs are sampled at
//            that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_write_arbiter;

   localparam int N   = 4;
   localparam int XW  = 8;
   localparam int YW  = 7;
   localparam int CW  = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      req;
   logic [N-1:0]      pix_valid;
   logic [N-1:0]      pix_last;
   logic [N*XW-1:0]   x_in;
   logic [N*YW-1:0]   y_in;
   logic [N*CW-1:0]   colour_in;
   logic [N-1:0]      grant;
   logic [N-1:0]      done;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [CW-1:0]     colour;
   logic              plot;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   vga_write_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .pix_valid (pix_valid),
      .pix_last  (pix_last),
      .x_in      (x_in),
      .y_in      (y_in),
      .colour_in (colour_in),
      .grant     (grant),
      .done      (done),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input int i, input logic [XW-1:0] xv,
                          input logic [YW-1:0] yv, input logic [CW-1:0] cv);
      x_in[i*XW +: XW]      = xv;
      y_in[i*YW +: YW]      = yv;
      colour_in[i*CW +: CW] = cv;
   endtask

   task automatic chk_ctl(input string tag, input logic [N-1:0] eg,
                          input logic [N-1:0] ed, input logic ep, input logic eb);
      n_checks++;
      assert ({grant, done, plot, busy} === {eg, ed, ep, eb}) else begin
         n_fail++;
         $error("FAIL %s: observed grant=%b done=%b plot=%b busy=%b expected grant=%b done=%b plot=%b busy=%b",
                tag, grant, done, plot, busy, eg, ed, ep, eb);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [XW-1:0] ex,
                          input logic [YW-1:0] ey, input logic [CW-1:0] ec);
      n_checks++;
      assert ({x, y, colour} === {ex, ey, ec}) else begin
         n_fail++;
         $error("FAIL %s: observed x=%0d y=%0d colour=%0d expected x=%0d y=%0d colour=%0d",
                tag, x, y, colour, ex, ey, ec);
      end
   endtask

   // One-pixel burst by whoever wins next; the winner must be exp_o.
   task automatic burst1(input int exp_o, input logic [N-1:0] reqv);
      logic [N-1:0] oh;
      oh = '0;
      oh[exp_o] = 1'b1;
      tick();
      chk_ctl($sformatf("rr grant %0d", exp_o), oh, '0, 1'b0, 1'b1);
      pix_valid = oh;
      pix_last  = oh;
      tick();
      chk_ctl($sformatf("rr last %0d", exp_o), '0, oh, 1'b1, 1'b1);
      chk_pix($sformatf("rr pix %0d", exp_o), 8'(8'h30 + exp_o), 7'(7'h10 + exp_o), 3'(exp_o));
      pix_valid = '0;
      pix_last  = '0;
      req       = reqv;
      tick();
      chk_ctl($sformatf("rr idle %0d", exp_o), '0, '0, 1'b0, 1'b0);
   endtask

   // Two-pixel burst with every requester presenting pixels all the time.
   task automatic burst2(input int exp_o);
      logic [N-1:0] oh;
      oh = '0;
      oh[exp_o] = 1'b1;
      pix_valid = '1;
      pix_last  = '0;
      for (int i = 0; i < N; i++) set_pix(i, 8'(8'h40 + 16*i), 7'(7'h20 + i), 3'(i));
      tick();
      chk_ctl($sformatf("ct grant %0d", exp_o), oh, '0, 1'b0, 1'b1);
      tick();
      chk_ctl($sformatf("ct p1 ctl %0d", exp_o), oh, '0, 1'b1, 1'b1);
      chk_pix($sformatf("ct p1 %0d", exp_o), 8'(8'h40 + 16*exp_o), 7'(7'h20 + exp_o), 3'(exp_o));
      for (int i = 0; i < N; i++) set_pix(i, 8'(8'h41 + 16*i), 7'(7'h20 + i), 3'(7 - i));
      pix_last = '1;
      tick();
      chk_ctl($sformatf("ct p2 ctl %0d", exp_o), '0, oh, 1'b1, 1'b1);
      chk_pix($sformatf("ct p2 %0d", exp_o), 8'(8'h41 + 16*exp_o), 7'(7'h20 + exp_o), 3'(7 - exp_o));
      tick();
      chk_ctl($sformatf("ct idle %0d", exp_o), '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = '0;
      pix_valid = '0;
      pix_last  = '0;
      x_in      = '0;
      y_in      = '0;
      colour_in = '0;
      tick();
      tick();
      reset_n = 1'b1;
      chk_ctl("reset ctl", '0, '0, 1'b0, 1'b0);
      chk_pix("reset pix", '0, '0, '0);

      // Single requester, three pixels
      req = 4'b0001;
      tick();
      chk_ctl("single grant", 4'b0001, '0, 1'b0, 1'b1);
      pix_valid = 4'b0001;
      set_pix(0, 8'd10, 7'd20, 3'd5);
      tick();
      chk_ctl("single p1 ctl", 4'b0001, '0, 1'b1, 1'b1);
      chk_pix("single p1", 8'd10, 7'd20, 3'd5);
      set_pix(0, 8'd11, 7'd20, 3'd5);
      tick();
      chk_ctl("single p2 ctl", 4'b0001, '0, 1'b1, 1'b1);
      chk_pix("single p2", 8'd11, 7'd20, 3'd5);
      set_pix(0, 8'd12, 7'd20, 3'd5);
      pix_last = 4'b0001;
      tick();
      chk_ctl("single p3 ctl", '0, 4'b0001, 1'b1, 1'b1);
      chk_pix("single p3", 8'd12, 7'd20, 3'd5);
      req       = '0;
      pix_valid = '0;
      pix_last  = '0;
      tick();
      chk_ctl("single idle", '0, '0, 1'b0, 1'b0);

      // Round-robin with req=1010; pointer is 1 after the single burst
      for (int i = 0; i < N; i++) set_pix(i, 8'(8'h30 + i), 7'(7'h10 + i), 3'(i));
      req = 4'b1010;
      burst1(1, 4'b1010);
      burst1(3, 4'b1010);
      burst1(1, 4'b1010);
      burst1(3, 4'b0000);

      // Contention: pointer back at 0, everyone requesting
      req = 4'b1111;
      burst2(0);
      burst2(1);
      burst2(2);
      burst2(3);
      burst2(0);
      req       = '0;
      pix_valid = '0;
      pix_last  = '0;
      tick();
      chk_ctl("ct drained", '0, '0, 1'b0, 1'b0);

      // Abort: pointer is 1 here, only requester 2 asks
      req = 4'b0100;
      set_pix(2, 8'd77, 7'd66, 3'd6);
      tick();
      chk_ctl("abort grant", 4'b0100, '0, 1'b0, 1'b1);
      pix_valid = 4'b0100;
      tick();
      chk_ctl("abort p1 ctl", 4'b0100, '0, 1'b1, 1'b1);
      chk_pix("abort p1", 8'd77, 7'd66, 3'd6);
      set_pix(2, 8'd78, 7'd66, 3'd6);
      req = 4'b1011;
      tick();
      chk_ctl("abort release", '0, '0, 1'b0, 1'b1);
      tick();
      chk_ctl("abort idle", '0, '0, 1'b0, 1'b0);
      pix_valid = '0;
      tick();
      chk_ctl("abort next grant", 4'b1000, '0, 1'b0, 1'b1);
      req = '0;
      tick();
      chk_ctl("abort2 release", '0, '0, 1'b0, 1'b1);
      tick();
      chk_ctl("abort2 idle", '0, '0, 1'b0, 1'b0);

      // Gaps: pointer is 0, requester 0 pauses for three cycles
      req = 4'b0001;
      tick();
      chk_ctl("gap grant", 4'b0001, '0, 1'b0, 1'b1);
      pix_valid = 4'b0001;
      set_pix(0, 8'd100, 7'd101, 3'd2);
      tick();
      chk_ctl("gap p1 ctl", 4'b0001, '0, 1'b1, 1'b1);
      chk_pix("gap p1", 8'd100, 7'd101, 3'd2);
      pix_valid = '0;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk_ctl($sformatf("gap hold %0d", g), 4'b0001, '0, 1'b0, 1'b1);
      end
      pix_valid = 4'b0001;
      pix_last  = 4'b0001;
      set_pix(0, 8'd159, 7'd119, 3'd7);
      tick();
      chk_ctl("gap last ctl", '0, 4'b0001, 1'b1, 1'b1);
      chk_pix("gap last", 8'd159, 7'd119, 3'd7);
      pix_valid = '0;
      pix_last  = '0;
      req       = '0;
      tick();
      chk_ctl("gap idle", '0, '0, 1'b0, 1'b0);

      // Reset mid-stream: pointer is 1, requester 2 streaming
      req = 4'b0100;
      tick();
      chk_ctl("mrst grant", 4'b0100, '0, 1'b0, 1'b1);
      pix_valid = 4'b0100;
      set_pix(2, 8'd5, 7'd6, 3'd3);
      tick();
      chk_ctl("mrst p1 ctl", 4'b0100, '0, 1'b1, 1'b1);
      reset_n = 1'b0;
      pix_last = 4'b0100;
      tick();
      chk_ctl("mrst ctl", '0, '0, 1'b0, 1'b0);
      chk_pix("mrst pix", '0, '0, '0);
      tick();
      reset_n   = 1'b1;
      pix_valid = '0;
      pix_last  = '0;
      req       = 4'b0101;
      tick();
      chk_ctl("post reset grant", 4'b0001, '0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #100000;
      $display("FAIL timeout: observed no end of stimulus, expected completion before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
